wb_arb_rr: RTL and testbench

WB_ARB_RR -- requirements
Module: wb_arb_rr

---
 rtl/wb_arb_pkg.sv | 12 +
 rtl/wb_arb_rr_pick.sv | 30 +++
 rtl/wb_arb_rr.sv | 165 ++++++++++++++++
 tb/tb_wb_arb_rr.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the round-robin Wishbone arbiter.
// Holds the arbiter state encoding and the value that disables the ack timeout.
package wb_arb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   localparam int TIMEOUT_DISABLED = 0;

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Combinational round-robin picker: one-hot grant for the first requester after last.
// Zero latency; a master equal to last has the lowest priority and wins only when it requests alone.
module wb_arb_rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  pick,
   output logic [IW-1:0] pick_idx
);

   always_comb begin
      int  idx;
      logic found;
      pick     = '0;
      pick_idx = '0;
      found    = 1'b0;
      idx      = 0;
      for (int off = 1; off <= N; off++) begin
         idx = (int'(last) + off) % N;
         if (!found && req[idx]) begin
            pick[idx] = 1'b1;
            pick_idx  = IW'(idx);
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_arb_rr.sv
// Round-robin Wishbone arbiter: N masters share one slave; grant follows m_cyc by one cycle.
// Slave request path and ack/err return are combinational; optional timeout errors a stalled access.
module wb_arb_rr
   import wb_arb_pkg::*;
#(
   parameter int N_MASTERS     = 4,
   parameter int WB_ADDR_WIDTH = 32,
   parameter int WB_DATA_WIDTH = 32,
   parameter int TIMEOUT       = 0
) (
   input  logic                                   clock,
   input  logic                                   reset_n,
   input  logic [N_MASTERS*WB_ADDR_WIDTH-1:0]     m_adr,
   input  logic [N_MASTERS*WB_DATA_WIDTH-1:0]     m_dat_w,
   input  logic [N_MASTERS*WB_DATA_WIDTH/8-1:0]   m_sel,
   input  logic [N_MASTERS*3-1:0]                 m_cti,
   input  logic [N_MASTERS*2-1:0]                 m_bte,
   input  logic [N_MASTERS-1:0]                   m_cyc,
   input  logic [N_MASTERS-1:0]                   m_stb,
   input  logic [N_MASTERS-1:0]                   m_we,
   output logic [WB_DATA_WIDTH-1:0]               m_dat_r,
   output logic [N_MASTERS-1:0]                   m_ack,
   output logic [N_MASTERS-1:0]                   m_err,
   output logic [WB_ADDR_WIDTH-1:0]               s_adr,
   output logic [WB_DATA_WIDTH-1:0]               s_dat_w,
   output logic [WB_DATA_WIDTH/8-1:0]             s_sel,
   output logic [2:0]                             s_cti,
   output logic [1:0]                             s_bte,
   output logic                                   s_cyc,
   output logic                                   s_stb,
   output logic                                   s_we,
   input  logic [WB_DATA_WIDTH-1:0]               s_dat_r,
   input  logic                                   s_ack,
   input  logic                                   s_err,
   output logic [N_MASTERS-1:0]                   gnt,
   output logic                                   gnt_valid
);

   localparam int  IW    = $clog2(N_MASTERS);
   localparam int  SW    = WB_DATA_WIDTH / 8;
   localparam bit  TO_EN = (TIMEOUT != TIMEOUT_DISABLED);
   localparam int  CW    = TO_EN ? $clog2(TIMEOUT + 1) : 1;

   state_t                 state_q, state_d;
   logic [N_MASTERS-1:0]   gnt_q, gnt_d;
   logic [IW-1:0]          last_q, last_d;
   logic [CW-1:0]          cnt_q, cnt_d;

   logic [N_MASTERS-1:0]   pick;
   logic [IW-1:0]          pick_idx;

   logic [WB_ADDR_WIDTH-1:0] adr_g;
   logic [WB_DATA_WIDTH-1:0] dat_g;
   logic [SW-1:0]            sel_g;
   logic [2:0]               cti_g;
   logic [1:0]               bte_g;
   logic                     cyc_g, stb_g, we_g;
   logic                     term, fire;

   wb_arb_rr_pick #(
      .N  (N_MASTERS),
      .IW (IW)
   ) u_pick (
      .req      (m_cyc),
      .last     (last_q),
      .pick     (pick),
      .pick_idx (pick_idx)
   );

   // gnt_q is all-zero in IDLE, so the mux naturally drives an idle slave bus.
   always_comb begin
      adr_g = '0;
      dat_g = '0;
      sel_g = '0;
      cti_g = '0;
      bte_g = '0;
      cyc_g = 1'b0;
      stb_g = 1'b0;
      we_g  = 1'b0;
      for (int i = 0; i < N_MASTERS; i++) begin
         if (gnt_q[i]) begin
            adr_g = m_adr[i*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
            dat_g = m_dat_w[i*WB_DATA_WIDTH +: WB_DATA_WIDTH];
            sel_g = m_sel[i*SW +: SW];
            cti_g = m_cti[i*3 +: 3];
            bte_g = m_bte[i*2 +: 2];
            cyc_g = m_cyc[i];
            stb_g = m_stb[i];
            we_g  = m_we[i];
         end
      end
   end

   // last_q tracks the granted index, so a releasing master is searched last.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      case (state_q)
         ST_IDLE: begin
            if (|m_cyc) begin
               state_d = ST_GRANT;
               gnt_d   = pick;
               last_d  = pick_idx;
            end
         end
         ST_GRANT: begin
            if (!cyc_g) begin
               if (|m_cyc) begin
                  gnt_d  = pick;
                  last_d = pick_idx;
               end else begin
                  state_d = ST_IDLE;
                  gnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      term  = s_ack | s_err;
      fire  = 1'b0;
      cnt_d = cnt_q;
      if (TO_EN && state_q == ST_GRANT && cyc_g && stb_g && !term && cnt_q == CW'(TIMEOUT))
         fire = 1'b1;
      if (state_q != ST_GRANT || term || fire || gnt_d != gnt_q)
         cnt_d = '0;
      else if (TO_EN && cyc_g && stb_g)
         cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         last_q  <= IW'(N_MASTERS - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   assign s_adr     = adr_g;
   assign s_dat_w   = dat_g;
   assign s_sel     = sel_g;
   assign s_cti     = cti_g;
   assign s_bte     = bte_g;
   assign s_we      = we_g;
   assign s_cyc     = cyc_g;
   assign s_stb     = stb_g & ~fire;
   assign m_dat_r   = s_dat_r;
   assign m_ack     = gnt_q & {N_MASTERS{s_ack}};
   assign m_err     = gnt_q & {N_MASTERS{s_err | fire}};
   assign gnt       = gnt_q;
   assign gnt_valid = (state_q == ST_GRANT);

endmodule

// File: tb/tb_wb_arb_rr.sv
// Scoreboard bench for wb_arb_rr (N=4, TIMEOUT=8): directed scenarios push expected
// grant changes and terminations; a negedge monitor pops and compares them.
module tb_wb_arb_rr;

   logic         clock = 1'b0;
   logic         reset_n;
   logic [127:0] m_adr;
   logic [127:0] m_dat_w;
   logic [15:0]  m_sel;
   logic [11:0]  m_cti;
   logic [7:0]   m_bte;
   logic [3:0]   m_cyc, m_stb, m_we;
   logic [31:0]  m_dat_r;
   logic [3:0]   m_ack, m_err;
   logic [31:0]  s_adr, s_dat_w;
   logic [3:0]   s_sel;
   logic [2:0]   s_cti;
   logic [1:0]   s_bte;
   logic         s_cyc, s_stb, s_we;
   logic [31:0]  s_dat_r;
   logic         s_ack, s_err;
   logic [3:0]   gnt;
   logic         gnt_valid;

   wb_arb_rr #(
      .N_MASTERS     (4),
      .WB_ADDR_WIDTH (32),
      .WB_DATA_WIDTH (32),
      .TIMEOUT       (8)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .m_adr     (m_adr),
      .m_dat_w   (m_dat_w),
      .m_sel     (m_sel),
      .m_cti     (m_cti),
      .m_bte     (m_bte),
      .m_cyc     (m_cyc),
      .m_stb     (m_stb),
      .m_we      (m_we),
      .m_dat_r   (m_dat_r),
      .m_ack     (m_ack),
      .m_err     (m_err),
      .s_adr     (s_adr),
      .s_dat_w   (s_dat_w),
      .s_sel     (s_sel),
      .s_cti     (s_cti),
      .s_bte     (s_bte),
      .s_cyc     (s_cyc),
      .s_stb     (s_stb),
      .s_we      (s_we),
      .s_dat_r   (s_dat_r),
      .s_ack     (s_ack),
      .s_err     (s_err),
      .gnt       (gnt),
      .gnt_valid (gnt_valid)
   );

   always #5 clock = ~clock;

   typedef struct { int cyc; logic [3:0] v; } gexp_t;
   typedef struct { int cyc; logic [3:0] ack; logic [3:0] err; } texp_t;

   gexp_t gq[$];
   texp_t tq[$];
   int    cycle  = 0;
   int    checks = 0;
   int    errors = 0;
   bit    ack_en = 1'b1;
   bit    both_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cycle);
      end
   endtask

   task automatic exp_g(input int cyc, input logic [3:0] v);
      gq.push_back('{cyc, v});
   endtask

   task automatic exp_t(input int cyc, input logic [3:0] ack, input logic [3:0] err);
      tq.push_back('{cyc, ack, err});
   endtask

   initial begin
      forever begin
         @(posedge clock);
         cycle++;
      end
   end

   // Slave: acks a pending strobe every other cycle; random read data each cycle.
   initial begin
      logic a;
      s_ack   = 1'b0;
      s_err   = 1'b0;
      s_dat_r = '0;
      forever begin
         @(posedge clock);
         #2;
         a       = ack_en && s_cyc && s_stb && !s_ack;
         s_ack   = a;
         s_err   = a && both_en;
         s_dat_r = $urandom;
      end
   end

   // Monitor: grant changes and terminations are popped from the scoreboard.
   initial begin
      logic [3:0] prev_gnt;
      gexp_t      ge;
      texp_t      te;
      int         g;
      prev_gnt = '0;
      forever begin
         @(negedge clock);
         if (gnt !== prev_gnt) begin
            if (gq.size() == 0) begin
               chk("gnt_unexpected_change", 64'(gnt), 64'(prev_gnt));
            end else begin
               ge = gq.pop_front();
               chk("gnt_value", 64'(gnt), 64'(ge.v));
               chk("gnt_cycle", 64'(cycle), 64'(ge.cyc));
            end
            prev_gnt = gnt;
         end
         if ((m_ack | m_err) != 4'b0) begin
            if (tq.size() == 0) begin
               chk("term_unexpected", 64'({m_ack, m_err}), 64'd0);
            end else begin
               te = tq.pop_front();
               chk("term_ack", 64'(m_ack), 64'(te.ack));
               chk("term_err", 64'(m_err), 64'(te.err));
               chk("term_cycle", 64'(cycle), 64'(te.cyc));
            end
         end
         chk("dat_r_bcast", 64'(m_dat_r), 64'(s_dat_r));
         chk("gnt_valid", 64'(gnt_valid), 64'(gnt != 4'b0));
         chk("gnt_onehot", 64'($countones(gnt) <= 1), 64'd1);
         if (gnt == 4'b0) begin
            chk("idle_s_cyc", 64'(s_cyc), 64'd0);
            chk("idle_s_stb", 64'(s_stb), 64'd0);
         end else begin
            g = 0;
            for (int i = 0; i < 4; i++) if (gnt[i]) g = i;
            chk("mirror_adr", 64'(s_adr), 64'(m_adr[g*32 +: 32]));
            chk("mirror_cyc", 64'(s_cyc), 64'(m_cyc[g]));
            chk("mirror_cti", 64'(s_cti), 64'(m_cti[g*3 +: 3]));
            if (m_err != 4'b0 && !s_err)
               chk("timeout_stb_low", 64'(s_stb), 64'd0);
            else
               chk("mirror_stb", 64'(s_stb), 64'(m_stb[g]));
         end
      end
   end

   // Master BFM: holds cyc/stb until the requested number of terminations.
   task automatic do_xfer(input int i, input int beats);
      int n = 0;
      int guard = 0;
      m_adr[i*32 +: 32]   = 32'h1000_0000 + 32'(i * 256);
      m_dat_w[i*32 +: 32] = 32'hA5A5_0000 + 32'(i);
      m_sel[i*4 +: 4]     = 4'hF;
      m_we[i]             = i[0];
      m_cti[i*3 +: 3]     = (beats > 1) ? 3'b010 : 3'b000;
      m_bte[i*2 +: 2]     = 2'b00;
      m_cyc[i]            = 1'b1;
      m_stb[i]            = 1'b1;
      while (n < beats && guard < 200) begin
         @(negedge clock);
         guard++;
         if (m_ack[i] || m_err[i]) begin
            n++;
            @(posedge clock);
            #1;
            if (n == beats - 1) m_cti[i*3 +: 3] = 3'b111;
         end
      end
      if (n < beats) begin
         checks++;
         errors++;
         $display("FAIL xfer_m%0d: got %0d terminations, expected %0d", i, n, beats);
      end
      m_cyc[i]        = 1'b0;
      m_stb[i]        = 1'b0;
      m_cti[i*3 +: 3] = 3'b000;
   endtask

   task automatic start(output int c);
      @(posedge clock);
      #1;
      c = cycle;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      int c;
      reset_n = 1'b0;
      m_adr   = '0;
      m_dat_w = '0;
      m_sel   = '0;
      m_cti   = '0;
      m_bte   = '0;
      m_we    = '0;
      m_cyc   = 4'b1000;
      m_stb   = 4'b1000;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_gnt_valid", 64'(gnt_valid), 64'd0);
      chk("rst_s_cyc", 64'(s_cyc), 64'd0);
      chk("rst_s_stb", 64'(s_stb), 64'd0);
      chk("rst_m_ack_err", 64'({m_ack, m_err}), 64'd0);
      m_cyc = '0;
      m_stb = '0;
      @(posedge clock);
      #3;
      reset_n = 1'b1;
      repeat (2) @(posedge clock);

      // m0 and m2 together: m0 first, m2 straight after with no idle cycle.
      start(c);
      exp_g(c+1, 4'b0001); exp_g(c+3, 4'b0100); exp_g(c+5, 4'b0000);
      exp_t(c+1, 4'b0001, 4'b0000); exp_t(c+3, 4'b0100, 4'b0000);
      fork
         do_xfer(0, 1);
         do_xfer(2, 1);
      join
      repeat (4) @(posedge clock);

      // m1 alone: ack routed only to m1.
      start(c);
      exp_g(c+1, 4'b0010); exp_g(c+3, 4'b0000);
      exp_t(c+1, 4'b0010, 4'b0000);
      do_xfer(1, 1);
      repeat (4) @(posedge clock);

      // m3 alone with ack and err together: both pass through.
      both_en = 1'b1;
      start(c);
      exp_g(c+1, 4'b1000); exp_g(c+3, 4'b0000);
      exp_t(c+1, 4'b1000, 4'b1000);
      do_xfer(3, 1);
      both_en = 1'b0;
      repeat (4) @(posedge clock);

      // All four request; m0 requests again: order 0,1,2,3,0.
      start(c);
      exp_g(c+1, 4'b0001); exp_g(c+3, 4'b0010); exp_g(c+5, 4'b0100);
      exp_g(c+7, 4'b1000); exp_g(c+9, 4'b0001); exp_g(c+11, 4'b0000);
      exp_t(c+1, 4'b0001, 4'b0); exp_t(c+3, 4'b0010, 4'b0); exp_t(c+5, 4'b0100, 4'b0);
      exp_t(c+7, 4'b1000, 4'b0); exp_t(c+9, 4'b0001, 4'b0);
      fork
         begin
            do_xfer(0, 1);
            @(posedge clock);
            #1;
            do_xfer(0, 1);
         end
         do_xfer(1, 1);
         do_xfer(2, 1);
         do_xfer(3, 1);
      join
      repeat (4) @(posedge clock);

      // m1 4-beat incrementing burst holds the grant while m3 waits.
      start(c);
      exp_g(c+1, 4'b0010); exp_g(c+9, 4'b1000); exp_g(c+11, 4'b0000);
      exp_t(c+1, 4'b0010, 4'b0); exp_t(c+3, 4'b0010, 4'b0); exp_t(c+5, 4'b0010, 4'b0);
      exp_t(c+7, 4'b0010, 4'b0); exp_t(c+9, 4'b1000, 4'b0);
      fork
         do_xfer(1, 4);
         do_xfer(3, 1);
      join
      repeat (4) @(posedge clock);

      // Silent slave: m1 gets a one-cycle err 8 cycles after its strobe reaches the slave.
      ack_en = 1'b0;
      start(c);
      exp_g(c+1, 4'b0010); exp_g(c+11, 4'b0000);
      exp_t(c+9, 4'b0000, 4'b0010);
      do_xfer(1, 1);
      ack_en = 1'b1;
      repeat (4) @(posedge clock);

      // Reset in the middle of an m2 burst, then re-arbitration after release.
      start(c);
      exp_g(c+1, 4'b0100); exp_g(c+4, 4'b0000); exp_g(c+7, 4'b0100); exp_g(c+9, 4'b0000);
      exp_t(c+1, 4'b0100, 4'b0); exp_t(c+3, 4'b0100, 4'b0); exp_t(c+7, 4'b0100, 4'b0);
      m_adr[64 +: 32] = 32'h2000_0200;
      m_cti[6 +: 3]   = 3'b010;
      m_cyc[2]        = 1'b1;
      m_stb[2]        = 1'b1;
      repeat (4) @(posedge clock);
      #3;
      reset_n = 1'b0;
      #1;
      chk("midrst_gnt", 64'(gnt), 64'd0);
      chk("midrst_gnt_valid", 64'(gnt_valid), 64'd0);
      chk("midrst_s_cyc", 64'(s_cyc), 64'd0);
      chk("midrst_s_stb", 64'(s_stb), 64'd0);
      repeat (2) @(posedge clock);
      #3;
      reset_n = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      m_cyc[2]      = 1'b0;
      m_stb[2]      = 1'b0;
      m_cti[6 +: 3] = 3'b000;
      repeat (5) @(posedge clock);

      chk("gnt_queue_drained", 64'(gq.size()), 64'd0);
      chk("term_queue_drained", 64'(tq.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
